regfile_wb_arbiter: RTL

Write-back arbiter and scoreboard for the single write port of the 32x32 register file. Up to NREQ producers (for example ALU, load unit, CSR/multi-cycle unit) compete for the port, and the block grants one of them per cycle in round-robin order. It registers the winning write onto the register file's WE3/A3/WD3 inputs. It also keeps a per-register busy scoreboard, so issue logic can detect read-after-write hazards on registers that still have a write outstanding.

---
 rtl/regfile_wb_arbiter_if.sv | 30 +++
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back producers, issue logic and the
// register-file write port. The arbiter takes the slave side; the producers,
// issue logic and register file together form the master side.
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 arb_hold;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [(1<<AW)-1:0]   busy;

  modport master (
    output req_valid, req_addr, req_data, arb_hold, issue_valid, issue_rd,
    input  req_ready, rf_we, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, arb_hold, issue_valid, issue_rd,
    output req_ready, rf_we, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// with a registered WE3/A3/WD3 stage and a per-register busy scoreboard used
// by issue logic for read-after-write hazard detection.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_onehot;
  logic [AW-1:0]   gnt_addr;
  logic [XLEN-1:0] gnt_data;

  // Round-robin pick: first valid requester at or above ptr, else wrap to the
  // lowest valid one below ptr. Held off during reset and while arb_hold is set.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (rst && !bus.arb_hold) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_vld && bus.req_valid[i] && (PW'(i) >= ptr_q)) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(i);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_vld && bus.req_valid[i] && (PW'(i) < ptr_q)) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end
  end

  // Decode the winner into a one-hot ready and mux out its address and data.
  always_comb begin
    gnt_onehot = '0;
    gnt_addr   = '0;
    gnt_data   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && (gnt_idx == PW'(i))) begin
        gnt_onehot[i] = 1'b1;
        gnt_addr      = bus.req_addr[i*AW +: AW];
        gnt_data      = bus.req_data[i*XLEN +: XLEN];
      end
    end
  end

  // A granted requester is by construction valid, so a grant is a transfer;
  // the pointer moves just past the winner and otherwise holds.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) begin
      if (gnt_idx == PW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + PW'(1);
      end
    end
  end

  // Write port stage: x0 transfers are accepted but never raise WE3, and the
  // address/data hold whenever no real write is launched.
  always_comb begin
    rf_we_d    = gnt_vld && (gnt_addr != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = gnt_addr;
      rf_wdata_d = gnt_data;
    end
  end

  // Scoreboard: commit clears first so a same-cycle issue to that register
  // re-marks it busy (the newer writer is still pending); x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.req_ready = gnt_onehot;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.busy      = busy_q;

endmodule
